// File: rtl/uart_rx_pl.sv
// uart_rx_pl: 8N1 UART receiver that samples at bit centres and holds each byte in a single-entry valid/ready register.
module uart_rx_pl #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk100,
  input  logic       rstn,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  if (DIV < 16) begin : g_div_chk
    $error("uart_rx_pl: CLK_HZ/BAUD must be at least 16");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d, data_q, data_d;
  logic [2:0]      idx_q, idx_d;
  logic            s1_q, s2_q, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic            tick, deliver, load;
  assign tick = cnt_q == '0;
  always_comb begin
    st_d    = st_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    sh_d    = sh_q;
    idx_d   = idx_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      IDLE: if (!s2_q) begin
        cnt_d = CW'(HALF - 1);
        st_d  = START;
      end
      START: if (tick) begin
        cnt_d = CW'(DIV - 1);
        idx_d = '0;
        st_d  = s2_q ? IDLE : DATA;
      end
      DATA: if (tick) begin
        sh_d  = {s2_q, sh_q[7:1]};
        cnt_d = CW'(DIV - 1);
        idx_d = idx_q + 3'd1;
        st_d  = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        deliver = s2_q;
        ferr_d  = !s2_q;
        st_d    = s2_q ? IDLE : BRK;
      end
      BRK: st_d = s2_q ? IDLE : BRK;
      default: st_d = IDLE;
    endcase
  end
  // a byte arriving while the holder is full and not being drained is dropped
  assign load    = deliver && (!valid_q || ready_i);
  assign valid_d = load || (valid_q && !ready_i);
  assign data_d  = load ? sh_q : data_q;
  assign ovr_d   = deliver && valid_q && !ready_i;
  always_ff @(posedge clk100) begin
    if (!rstn) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      st_q    <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s1_q    <= rxd_i;
      s2_q    <= s1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = st_q != IDLE;
endmodule

// File: tb/tb_uart_rx_pl.sv
// tb_uart_rx_pl: directed checks of uart_rx_pl at 1 Mbaud (DIV = 100, HALF = 50) to keep the run short.
module tb_uart_rx_pl;
  localparam int BT  = 100;
  localparam int LAT = 2 + 50 + 9 * BT + 1;
  logic       clk100 = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;
  int         cyc = 0;
  int         passed = 0, fails = 0, total = 0;
  int         ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0;
  logic       vprev = 1'b0;
  logic [7:0] rx_d[$];
  int         rx_t[$];
  uart_rx_pl #(.CLK_HZ(100000000), .BAUD(1000000)) dut (
    .clk100(clk100), .rstn(rstn), .rxd_i(rxd_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );
  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;
  always @(negedge clk100) begin
    vprev    <= valid_o;
    ferr_cnt <= ferr_cnt + int'(frame_err_o);
    ovr_cnt  <= ovr_cnt + int'(overrun_o);
    busy_cnt <= busy_cnt + int'(busy_o);
    if (valid_o && !vprev) begin
      rx_d.push_back(data_o);
      rx_t.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk100);
  endtask
  // leaves the line at the stop level so a low stop bit can run straight into a break
  task automatic send_byte(input logic [7:0] b, input int bt, input logic stop);
    rxd_i = 1'b0;
    wait_n(bt);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      wait_n(bt);
    end
    rxd_i = stop;
    wait_n(bt);
  endtask
  initial begin
    int n0, f0, o0, b0, t0;
    wait_n(3);
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ferr", frame_err_o, 1'b0);
    chk("rst_ovr", overrun_o, 1'b0);
    rstn = 1'b1;
    wait_n(20000);
    chk("idle_rx", rx_d.size(), 0);
    chk("idle_busy", busy_cnt, 0);
    chk("idle_err", ferr_cnt + ovr_cnt, 0);
    chk("idle_data", data_o, 8'h00);
    n0 = rx_d.size();
    t0 = cyc;
    send_byte(8'h55, BT, 1'b1);
    send_byte(8'hA3, BT, 1'b1);
    wait_n(200);
    chk("b2b_count", rx_d.size() - n0, 2);
    chk("b2b_d0", rx_d[n0], 8'h55);
    chk("b2b_d1", rx_d[n0+1], 8'hA3);
    chk("b2b_lat", rx_t[n0] - t0, LAT);
    chk("b2b_gap_ok", (rx_t[n0+1] - rx_t[n0] >= 10 * BT - 2) && (rx_t[n0+1] - rx_t[n0] <= 10 * BT + 2), 1'b1);
    chk("b2b_pulse", valid_o, 1'b0);
    n0 = rx_d.size();
    f0 = ferr_cnt;
    b0 = busy_cnt;
    rxd_i = 1'b0;
    wait_n(20);
    rxd_i = 1'b1;
    wait_n(300);
    chk("glitch_seen", busy_cnt > b0, 1'b1);
    chk("glitch_idle", busy_o, 1'b0);
    chk("glitch_rx", rx_d.size(), n0);
    chk("glitch_err", ferr_cnt, f0);
    send_byte(8'h3C, BT, 1'b0);
    wait_n(5000);
    chk("brk_busy", busy_o, 1'b1);
    rxd_i = 1'b1;
    wait_n(200);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_no_rx", rx_d.size(), n0);
    send_byte(8'h7E, BT, 1'b1);
    wait_n(200);
    chk("brk_next_cnt", rx_d.size() - n0, 1);
    chk("brk_next_data", rx_d[n0], 8'h7E);
    chk("brk_ferr_once", ferr_cnt - f0, 1);
    n0 = rx_d.size();
    o0 = ovr_cnt;
    ready_i = 1'b0;
    send_byte(8'h11, BT, 1'b1);
    send_byte(8'h22, BT, 1'b1);
    wait_n(200);
    chk("ovr_valid", valid_o, 1'b1);
    chk("ovr_data", data_o, 8'h11);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_loads", rx_d.size() - n0, 1);
    ready_i = 1'b1;
    wait_n(1);
    chk("ovr_consumed", valid_o, 1'b0);
    chk("ovr_hold", data_o, 8'h11);
    n0 = rx_d.size();
    rxd_i = 1'b0;
    wait_n(5 * BT);
    rxd_i = 1'b1;
    wait_n(50);
    rstn = 1'b0;
    wait_n(1);
    rstn = 1'b1;
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_data", data_o, 8'h00);
    wait_n(49 + 5 * BT + 200);
    chk("mrst_no_rx", rx_d.size(), n0);
    send_byte(8'h0F, 97, 1'b1);
    wait_n(200);
    chk("fast_cnt", rx_d.size() - n0, 1);
    chk("fast_data", rx_d[n0], 8'h0F);
    send_byte(8'hE1, 103, 1'b1);
    wait_n(200);
    chk("slow_cnt", rx_d.size() - n0, 2);
    chk("slow_data", rx_d[n0+1], 8'hE1);
    chk("end_err", ferr_cnt - f0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
